bless_port_alloc: RTL and testbench
===================================

// Module: bless_port_alloc
// PURPOSE
//  Per-router BLESS port allocator; produces the 5x3b route_config that drives the 5x5 crossbar.
//  Oldest-first arbitration, each flit takes a productive port else is deflected, one ejection per
//  cycle, injection only when a network slot is free. One pipeline stage; feeds crossbar next cycle.
// PARAMETERS
//  MY_X     0  this node's X coordinate
//  MY_Y     0  this node's Y coordinate
//  COORD_W  4  coordinate field width
//  AGE_W    8  age field width
//  CTRL_W   1+2*COORD_W+AGE_W  control word {age, dst_y, dst_x, valid}; valid = bit 0
// PORTS
//  clk           in   1         clock
//  rst           in   1         reset, synchronous, active-high
//  ctrl0..3_in   in   CTRL_W    network input control, N/S/E/W (ports 0..3)
//  ctrl4_in      in   CTRL_W    local injection control (port 4)
//  route_config  out  15        {out4,out3,out2,out1,out0}, 3b each = selected input idx, 3'b111 = idle
//  ctrl0..4_out  out  CTRL_W    registered per-input control, age updated, to crossbar ctrl inputs
//  inj_ready     out  1         injection slot available this cycle (combinational)
//  defl_count    out  16        deflection counter (only with BLESS_DEFL_STATS_EN)
// BEHAVIOUR
//  - Reset: route_config=15'h7FFF, ctrl*_out=0, inj_ready=0, rr_ptr=0, defl_count=0.
//  - Latency 1: inputs sampled at edge N -> route_config/ctrl*_out valid after edge N.
//  - Ports: 0=N (dst_y<MY_Y), 1=S (dst_y>MY_Y), 2=E (dst_x>MY_X), 3=W (dst_x<MY_X), 4=local/eject.
//  - inj_ready = !rst && (count of valid ctrl0..3_in < 4). Input 4 participates only if valid && inj_ready;
//    otherwise it is ignored and never selected.
//  - Priority order: higher age first; equal ages -> smaller (idx - rr_ptr) mod 5 first.
//  - rr_ptr: 3b, increments each cycle with >=1 participating flit, wraps 4->0.
//  - Allocation in priority order, each flit:
//    dst==(MY_X,MY_Y): port 4 if free, else deflect.
//    else: X-productive port (E/W) if free, else Y-productive (N/S) if free, else deflect.
//    deflect: lowest-index free port among 0..3; port 4 is never a deflection target.
//  - <=4 participating flits always -> every participant gets exactly one output; no drops.
//  - Unassigned outputs = 3'b111. An output is never assigned twice.
//  - ctrlK_out: participating valid -> age+1 saturating at 2^AGE_W-1, other fields unchanged;
//    non-participating/invalid -> all zero.
//  - Reset mid-stream: in-flight allocation discarded; outputs at reset values after the reset edge.
// CONFIGURATION
//  BLESS_DEFL_STATS_EN defined: defl_count adds number of flits deflected each cycle (non-productive
//    port, incl. lost ejection), saturates at 16'hFFFF, cleared by rst.
//  Not defined: defl_count port absent; no counter logic.
// TESTING
//  1. ctrl0_in valid dst=(MY_X+1,MY_Y) age 3 -> next cycle route_config[8:6]=3'b000, other fields
//     3'b111, ctrl0_out age 4.
//  2. ctrl0 age 5, ctrl1 age 9, both dst east -> ctrl1 gets port 2, ctrl0 port 0 (lowest free);
//     defl_count +1.
//  3. ctrl0..3 valid + ctrl4 valid -> inj_ready=0, no field equals 3'b100, ctrl4_out=0.
//  4. ctrl2 age 7 and ctrl3 age 2 both dst=(MY_X,MY_Y) -> route_config[14:12]=3'b010,
//     ctrl3 deflected to port 0.
//  5. ctrl0, ctrl1 age 4, both want E, two consecutive cycles -> winner ctrl0 then ctrl1 (rr_ptr 0->1).
//  6. age 255 input -> ctrl_out age 255; rst asserted mid-traffic -> route_config=15'h7FFF, all ctrl_out 0.

Source files
------------

// File: rtl/bless_port_alloc.sv
// BLESS port allocator: oldest-first, productive-else-deflect routing for a 5x5 crossbar, one stage.
// Optional deflection counter (defl_count port) enabled by defining BLESS_DEFL_STATS_EN.
module bless_port_alloc #(
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0,
  parameter int COORD_W = 4,
  parameter int AGE_W   = 8,
  parameter int CTRL_W  = 1 + 2*COORD_W + AGE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl0_in,
  input  logic [CTRL_W-1:0] ctrl1_in,
  input  logic [CTRL_W-1:0] ctrl2_in,
  input  logic [CTRL_W-1:0] ctrl3_in,
  input  logic [CTRL_W-1:0] ctrl4_in,
  output logic [14:0]       route_config,
  output logic [CTRL_W-1:0] ctrl0_out,
  output logic [CTRL_W-1:0] ctrl1_out,
  output logic [CTRL_W-1:0] ctrl2_out,
  output logic [CTRL_W-1:0] ctrl3_out,
  output logic [CTRL_W-1:0] ctrl4_out,
`ifdef BLESS_DEFL_STATS_EN
  output logic [15:0]       defl_count,
`endif
  output logic              inj_ready
);

  localparam logic [COORD_W-1:0] LX = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] LY = COORD_W'(MY_Y);
  localparam int KEY_W = AGE_W + 3;

  logic [CTRL_W-1:0] w_in [5];
  logic [4:0]        w_part;
  logic [2:0]        w_net_cnt;
  logic              w_inj_ready;
  logic [3:0]        w_dist [5];
  logic [KEY_W-1:0]  w_key [5];
  logic [2:0]        w_rank [5];
  logic [14:0]       w_route;
  logic [4:0]        w_free;
  logic [2:0]        w_defl;
  logic [2:0]        w_sel;
  logic              w_prod;
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;
  logic [AGE_W-1:0]  w_age [5];

  logic [14:0]       r_route;
  logic [CTRL_W-1:0] r_ctrl [5];
  logic [2:0]        r_rr;

  assign w_in[0] = ctrl0_in;
  assign w_in[1] = ctrl1_in;
  assign w_in[2] = ctrl2_in;
  assign w_in[3] = ctrl3_in;
  assign w_in[4] = ctrl4_in;

  assign w_net_cnt   = 3'(ctrl0_in[0]) + 3'(ctrl1_in[0]) + 3'(ctrl2_in[0]) + 3'(ctrl3_in[0]);
  assign w_inj_ready = !rst && (w_net_cnt != 3'd4);
  assign w_part      = {ctrl4_in[0] && w_inj_ready, ctrl3_in[0], ctrl2_in[0], ctrl1_in[0], ctrl0_in[0]};
  assign inj_ready   = w_inj_ready;

  // Key = {age, 4 - rotated index}: larger key wins, and keys are unique across inputs.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_dist[i] = 4'(i) + 4'd5 - {1'b0, r_rr};
      if (w_dist[i] >= 4'd5) w_dist[i] = w_dist[i] - 4'd5;
      w_key[i]  = {w_in[i][CTRL_W-1 -: AGE_W], 3'd4 - w_dist[i][2:0]};
      w_age[i]  = (&w_in[i][CTRL_W-1 -: AGE_W]) ? w_in[i][CTRL_W-1 -: AGE_W]
                                                 : w_in[i][CTRL_W-1 -: AGE_W] + AGE_W'(1);
    end
    for (int i = 0; i < 5; i++) begin
      w_rank[i] = 3'd0;
      for (int j = 0; j < 5; j++)
        if (w_part[j] && (w_key[j] > w_key[i])) w_rank[i] = w_rank[i] + 3'd1;
    end
  end

  // Walk participants by rank; each grabs a productive port or the lowest free network port.
  always_comb begin
    w_route = '1;
    w_free  = '1;
    w_defl  = '0;
    w_sel   = '1;
    w_prod  = 1'b0;
    w_dx    = '0;
    w_dy    = '0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 5; i++) begin
        if (w_part[i] && (w_rank[i] == 3'(r))) begin
          w_dx   = w_in[i][COORD_W:1];
          w_dy   = w_in[i][2*COORD_W:COORD_W+1];
          w_sel  = 3'b111;
          if (w_dx == LX && w_dy == LY) begin
            if (w_free[4]) w_sel = 3'd4;
          end else if (w_dx > LX && w_free[2]) w_sel = 3'd2;
          else if (w_dx < LX && w_free[3])     w_sel = 3'd3;
          else if (w_dy < LY && w_free[0])     w_sel = 3'd0;
          else if (w_dy > LY && w_free[1])     w_sel = 3'd1;
          w_prod = (w_sel != 3'b111);
          if (!w_prod)
            for (int p = 3; p >= 0; p--)
              if (w_free[p]) w_sel = 3'(p);
          for (int p = 0; p < 5; p++) begin
            if (w_sel == 3'(p)) begin
              w_route[3*p +: 3] = 3'(i);
              w_free[p]         = 1'b0;
            end
          end
          if (!w_prod) w_defl = w_defl + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_route <= '1;
      r_rr    <= '0;
      for (int i = 0; i < 5; i++) r_ctrl[i] <= '0;
    end else begin
      r_route <= w_route;
      if (|w_part) r_rr <= (r_rr == 3'd4) ? 3'd0 : r_rr + 3'd1;
      for (int i = 0; i < 5; i++)
        r_ctrl[i] <= w_part[i] ? {w_age[i], w_in[i][CTRL_W-AGE_W-1:0]} : '0;
    end
  end

  assign route_config = r_route;
  assign ctrl0_out    = r_ctrl[0];
  assign ctrl1_out    = r_ctrl[1];
  assign ctrl2_out    = r_ctrl[2];
  assign ctrl3_out    = r_ctrl[3];
  assign ctrl4_out    = r_ctrl[4];

`ifdef BLESS_DEFL_STATS_EN
  logic [15:0] r_defl;
  logic [16:0] w_defl_sum;
  assign w_defl_sum = {1'b0, r_defl} + 17'(w_defl);
  always_ff @(posedge clk) begin
    if (rst) r_defl <= '0;
    else     r_defl <= w_defl_sum[16] ? 16'hFFFF : w_defl_sum[15:0];
  end
  assign defl_count = r_defl;
`else
  logic w_unused_defl;
  assign w_unused_defl = ^w_defl;
`endif

endmodule

// File: tb/tb_bless_port_alloc.sv
// Directed bench for bless_port_alloc at node (2,2); expected routes are hand-computed per vector.
module tb_bless_port_alloc;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] c_in [5];
  logic [14:0]   route_config;
  logic [CW-1:0] c0_out, c1_out, c2_out, c3_out, c4_out;
  logic          inj_ready;
`ifdef BLESS_DEFL_STATS_EN
  logic [15:0]   defl_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bless_port_alloc #(.MY_X(2), .MY_Y(2), .COORD_W(4), .AGE_W(8)) dut (
    .clk(clk), .rst(rst),
    .ctrl0_in(c_in[0]), .ctrl1_in(c_in[1]), .ctrl2_in(c_in[2]),
    .ctrl3_in(c_in[3]), .ctrl4_in(c_in[4]),
    .route_config(route_config),
    .ctrl0_out(c0_out), .ctrl1_out(c1_out), .ctrl2_out(c2_out),
    .ctrl3_out(c3_out), .ctrl4_out(c4_out),
`ifdef BLESS_DEFL_STATS_EN
    .defl_count(defl_count),
`endif
    .inj_ready(inj_ready)
  );

  function automatic logic [CW-1:0] mk(input int age, input int dy, input int dx);
    return {8'(age), 4'(dy), 4'(dx), 1'b1};
  endfunction

  function automatic logic [14:0] rc(input int o4, input int o3, input int o2, input int o1, input int o0);
    return {3'(o4), 3'(o3), 3'(o2), 3'(o1), 3'(o0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_in();
    for (int i = 0; i < 5; i++) c_in[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    rst = 1'b0;
  endtask

  // Ports: 0=N(dy<2) 1=S(dy>2) 2=E(dx>2) 3=W(dx<2) 4=eject(dst==(2,2))
  int win_tbl [6] = '{1, 1, 3, 3, 1, 1};

  initial begin
    rst = 1'b1;
    clear_in();
    tick(); tick();
    check("rst_route", 32'(route_config), 32'h7FFF);
    check("rst_c0", 32'(c0_out), 0);
    check("rst_c4", 32'(c4_out), 0);
    check("rst_inj", 32'(inj_ready), 0);
`ifdef BLESS_DEFL_STATS_EN
    check("rst_defl", 32'(defl_count), 0);
`endif
    rst = 1'b0;

    // single eastbound flit
    c_in[0] = mk(3, 2, 3);
    tick();
    check("t1_route", 32'(route_config), 32'(rc(7, 7, 0, 7, 7)));
    check("t1_c0", 32'(c0_out), 32'(mk(4, 2, 3)));
    check("t1_c1", 32'(c1_out), 0);

    // older flit wins east, younger deflected to N
    do_reset();
    c_in[0] = mk(5, 2, 3);
    c_in[1] = mk(9, 2, 3);
    tick();
    check("t2_route", 32'(route_config), 32'(rc(7, 7, 1, 7, 0)));
    check("t2_c0", 32'(c0_out), 32'(mk(6, 2, 3)));
    check("t2_c1", 32'(c1_out), 32'(mk(10, 2, 3)));
`ifdef BLESS_DEFL_STATS_EN
    check("t2_defl", 32'(defl_count), 1);
`endif

    // four network flits block injection
    do_reset();
    c_in[0] = mk(1, 2, 3);
    c_in[1] = mk(1, 2, 1);
    c_in[2] = mk(1, 1, 2);
    c_in[3] = mk(1, 3, 2);
    c_in[4] = mk(1, 2, 2);
    #1;
    check("t3_inj", 32'(inj_ready), 0);
    tick();
    check("t3_route", 32'(route_config), 32'(rc(7, 1, 0, 3, 2)));
    check("t3_c4", 32'(c4_out), 0);
    check("t3_c2", 32'(c2_out), 32'(mk(2, 1, 2)));
`ifdef BLESS_DEFL_STATS_EN
    check("t3_defl", 32'(defl_count), 0);
`endif

    // two ejection candidates: older ejects, younger deflected
    clear_in();
    c_in[2] = mk(7, 2, 2);
    c_in[3] = mk(2, 2, 2);
    #1;
    check("t4_inj", 32'(inj_ready), 1);
    tick();
    check("t4_route", 32'(route_config), 32'(rc(2, 7, 7, 7, 3)));
`ifdef BLESS_DEFL_STATS_EN
    check("t4_defl", 32'(defl_count), 1);
`endif

    // equal ages: round-robin pointer alternates winner
    do_reset();
    c_in[0] = mk(4, 2, 3);
    c_in[1] = mk(4, 2, 3);
    tick();
    check("t5_route_a", 32'(route_config), 32'(rc(7, 7, 0, 7, 1)));
    tick();
    check("t5_route_b", 32'(route_config), 32'(rc(7, 7, 1, 7, 0)));
`ifdef BLESS_DEFL_STATS_EN
    check("t5_defl", 32'(defl_count), 2);
`endif

    // saturated age plus an injected northbound flit
    clear_in();
    c_in[0] = mk(255, 2, 3);
    c_in[4] = mk(7, 1, 2);
    #1;
    check("t6_inj", 32'(inj_ready), 1);
    tick();
    check("t6_route", 32'(route_config), 32'(rc(7, 7, 0, 7, 4)));
    check("t6_c0_sat", 32'(c0_out), 32'(mk(255, 2, 3)));
    check("t6_c4", 32'(c4_out), 32'(mk(8, 1, 2)));

    // reset arriving with traffic present
    c_in[1] = mk(9, 3, 2);
    rst = 1'b1;
    #1;
    check("t6_rst_inj", 32'(inj_ready), 0);
    tick();
    check("t6_rst_route", 32'(route_config), 32'h7FFF);
    check("t6_rst_c0", 32'(c0_out), 0);
    check("t6_rst_c1", 32'(c1_out), 0);
    check("t6_rst_c4", 32'(c4_out), 0);
`ifdef BLESS_DEFL_STATS_EN
    check("t6_rst_defl", 32'(defl_count), 0);
`endif
    rst = 1'b0;

    // pointer walk through a full wrap with inputs 1 and 3
    do_reset();
    c_in[1] = mk(4, 2, 3);
    c_in[3] = mk(4, 2, 3);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t7_rr%0d", k), 32'(route_config),
            32'(rc(7, 7, win_tbl[k], 7, (win_tbl[k] == 1) ? 3 : 1)));
    end
`ifdef BLESS_DEFL_STATS_EN
    check("t7_defl", 32'(defl_count), 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
